ycbcr_422_packer: RTL and testbench

//  Consumes the per-pixel 4:4:4 Y/Cb/Cr stream produced by the RGB->YCbCr stage.

---
 rtl/ycbcr_422_packer.sv | 200 ++++++++++++++++++++
 tb/tb_ycbcr_422_packer.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ycbcr_422_packer.sv
// ---------------------------------------------------------------------------
// ycbcr_422_packer
//
// Purpose:
//   Converts a per-pixel 4:4:4 Y/Cb/Cr stream into a 4:2:2 stream of
//   16-bit words. Each pixel pair produces {Cb,Y0} followed by {Cr,Y1}.
//   A column counter tracks line position so that an odd-width line closes
//   by duplicating its last pixel, and the final word of every line is
//   flagged with out_eol.
//
// Configuration:
//   CHROMA_AVG_EN  defined   -> output chroma is the rounded pair average
//                  undefined -> output chroma is pixel-0 chroma (decimation)
//
// Parameters:
//   DATA_W  bits per component
//   LINE_W  pixels per line (>= 1, odd allowed)
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   input pixel valid
//   in_ready   block accepts a pixel this cycle
//   in_y       luma
//   in_cb      blue-difference chroma
//   in_cr      red-difference chroma
//   out_valid  output word valid
//   out_ready  downstream accepts the word
//   out_data   {chroma, luma}
//   out_is_cb  1: word carries Cb (first of pair), 0: Cr
//   out_eol    1 on the final word of a line
// ---------------------------------------------------------------------------
module ycbcr_422_packer #(
    parameter int DATA_W = 8,
    parameter int LINE_W = 640
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_y,
    input  logic [DATA_W-1:0]   in_cb,
    input  logic [DATA_W-1:0]   in_cr,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*DATA_W-1:0] out_data,
    output logic                out_is_cb,
    output logic                out_eol
);

    // A one-pixel line still needs a 1-bit counter to keep widths legal.
    localparam int               COL_W    = (LINE_W > 1) ? $clog2(LINE_W) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LINE_W - 1);

    typedef enum logic [1:0] {
        S_P0, // await pixel 0
        S_P1, // await pixel 1
        S_W0, // emit Cb word
        S_W1  // emit Cr word
    } state_t;

    state_t            state_q, state_d;
    logic [COL_W-1:0]  col_q,   col_d;
    logic [DATA_W-1:0] y0_q,    y0_d;
    logic [DATA_W-1:0] y1_q,    y1_d;
    logic [DATA_W-1:0] cb0_q,   cb0_d;
    logic [DATA_W-1:0] cr0_q,   cr0_d;
`ifdef CHROMA_AVG_EN
    logic [DATA_W-1:0] cb1_q,   cb1_d;
    logic [DATA_W-1:0] cr1_q,   cr1_d;
`endif
    logic              eol_q,   eol_d;   // current pair closes the line

    logic              in_fire;
    logic              out_fire;
    logic              col_last;
    logic [COL_W-1:0]  col_next;
    logic [DATA_W-1:0] cb_o;
    logic [DATA_W-1:0] cr_o;

    // in_ready is a state decode, forced low while reset is held.
    assign in_ready  = ((state_q == S_P0) || (state_q == S_P1)) && !rst;
    assign out_valid = (state_q == S_W0) || (state_q == S_W1);
    assign in_fire   = in_valid && in_ready;
    assign out_fire  = out_valid && out_ready;
    assign col_last  = (col_q == COL_LAST);
    assign col_next  = col_last ? '0 : col_q + COL_W'(1);

`ifdef CHROMA_AVG_EN
    // One extra bit holds the carry of a+b+1, so the rounded mean never wraps.
    logic [DATA_W:0] cb_sum;
    logic [DATA_W:0] cr_sum;
    assign cb_sum = {1'b0, cb0_q} + {1'b0, cb1_q} + (DATA_W+1)'(1);
    assign cr_sum = {1'b0, cr0_q} + {1'b0, cr1_q} + (DATA_W+1)'(1);
    assign cb_o   = cb_sum[DATA_W:1];
    assign cr_o   = cr_sum[DATA_W:1];
`else
    assign cb_o   = cb0_q;
    assign cr_o   = cr0_q;
`endif

    // Words come straight from held registers, so they stay stable under
    // backpressure and read as zero after reset.
    assign out_data  = (state_q == S_W0) ? {cb_o, y0_q} : {cr_o, y1_q};
    assign out_is_cb = (state_q == S_W0);
    assign out_eol   = (state_q == S_W1) && eol_q;

    always_comb begin
        // NOTE: every signal gets a hold default first so no path infers a latch.
        state_d = state_q;
        col_d   = col_q;
        y0_d    = y0_q;
        y1_d    = y1_q;
        cb0_d   = cb0_q;
        cr0_d   = cr0_q;
`ifdef CHROMA_AVG_EN
        cb1_d   = cb1_q;
        cr1_d   = cr1_q;
`endif
        eol_d   = eol_q;

        case (state_q)
            S_P0: begin
                if (in_fire) begin
                    y0_d  = in_y;
                    cb0_d = in_cb;
                    cr0_d = in_cr;
                    col_d = col_next;
                    if (col_last) begin
                        // Odd line end: pixel 0 stands in for the missing pixel 1.
                        y1_d    = in_y;
`ifdef CHROMA_AVG_EN
                        cb1_d   = in_cb;
                        cr1_d   = in_cr;
`endif
                        eol_d   = 1'b1;
                        state_d = S_W0;
                    end else begin
                        eol_d   = 1'b0;
                        state_d = S_P1;
                    end
                end
            end
            S_P1: begin
                if (in_fire) begin
                    y1_d    = in_y;
`ifdef CHROMA_AVG_EN
                    cb1_d   = in_cb;
                    cr1_d   = in_cr;
`endif
                    eol_d   = col_last;
                    col_d   = col_next;
                    state_d = S_W0;
                end
            end
            S_W0: begin
                if (out_fire) begin
                    state_d = S_W1;
                end
            end
            S_W1: begin
                if (out_fire) begin
                    state_d = S_P0;
                end
            end
            default: state_d = S_P0;
        endcase
    end

    // NOTE: data registers are reset too, so the idle output word is a defined zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_P0;
            col_q   <= '0;
            y0_q    <= '0;
            y1_q    <= '0;
            cb0_q   <= '0;
            cr0_q   <= '0;
`ifdef CHROMA_AVG_EN
            cb1_q   <= '0;
            cr1_q   <= '0;
`endif
            eol_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q <= state_d;
            col_q   <= col_d;
            y0_q    <= y0_d;
            y1_q    <= y1_d;
            cb0_q   <= cb0_d;
            cr0_q   <= cr0_d;
`ifdef CHROMA_AVG_EN
            cb1_q   <= cb1_d;
            cr1_q   <= cr1_d;
`endif
            eol_q   <= eol_d;
        end
    end

endmodule

// File: tb/tb_ycbcr_422_packer.sv
// ---------------------------------------------------------------------------
// tb_ycbcr_422_packer
//
// Directed bench for ycbcr_422_packer. Three instances share clk/rst:
//   index 0: LINE_W=640, index 1: LINE_W=3, index 2: LINE_W=5.
// Expected words are hand-computed for both chroma builds; the randomised
// gap run uses a small pair model and an expected-word queue.
// ---------------------------------------------------------------------------
module tb_ycbcr_422_packer;

    localparam int LW2    = 5;
    localparam int LINES  = 4;
    localparam int NPIX   = LW2 * LINES;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iv   [3];
    logic        ir   [3];
    logic [7:0]  iy   [3];
    logic [7:0]  icb  [3];
    logic [7:0]  icr  [3];
    logic        ov   [3];
    logic        ordy [3];
    logic [15:0] od   [3];
    logic        ocb  [3];
    logic        oeol [3];

    int n_checks = 0;
    int n_errs   = 0;

    always #5 clk = ~clk;

    ycbcr_422_packer #(.DATA_W(8), .LINE_W(640)) u_dut0 (
        .clk(clk), .rst(rst),
        .in_valid(iv[0]), .in_ready(ir[0]), .in_y(iy[0]), .in_cb(icb[0]), .in_cr(icr[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_data(od[0]),
        .out_is_cb(ocb[0]), .out_eol(oeol[0])
    );
    ycbcr_422_packer #(.DATA_W(8), .LINE_W(3)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(iv[1]), .in_ready(ir[1]), .in_y(iy[1]), .in_cb(icb[1]), .in_cr(icr[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_data(od[1]),
        .out_is_cb(ocb[1]), .out_eol(oeol[1])
    );
    ycbcr_422_packer #(.DATA_W(8), .LINE_W(LW2)) u_dut2 (
        .clk(clk), .rst(rst),
        .in_valid(iv[2]), .in_ready(ir[2]), .in_y(iy[2]), .in_cb(icb[2]), .in_cr(icr[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_data(od[2]),
        .out_is_cb(ocb[2]), .out_eol(oeol[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Present one pixel and hold it until the DUT accepts it (bounded).
    task automatic send_pixel(input int k, input logic [7:0] y, input logic [7:0] cb,
                              input logic [7:0] cr);
        int n = 0;
        @(negedge clk);
        iv[k] = 1'b1; iy[k] = y; icb[k] = cb; icr[k] = cr;
        while (!ir[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ir[k]) check("send_timeout", 32'(ir[k]), 32'd1);
        @(posedge clk);
        #1;
        iv[k] = 1'b0;
    endtask

    // Wait for a word (bounded), check it, then complete the handshake.
    task automatic expect_word(input int k, input string tag, input logic [15:0] data,
                               input logic is_cb, input logic eol);
        int n = 0;
        @(negedge clk);
        while (!ov[k] && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(ov[k]), 32'd1);
        check({tag, "_data"},  32'(od[k]), 32'(data));
        check({tag, "_is_cb"}, 32'(ocb[k]), 32'(is_cb));
        check({tag, "_eol"},   32'(oeol[k]), 32'(eol));
        ordy[k] = 1'b1;
        @(posedge clk);
        #1;
        ordy[k] = 1'b0;
    endtask

    function automatic logic [7:0] chroma(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {1'b0, b} + 9'd1;
`ifdef CHROMA_AVG_EN
        return s[8:1];
`else
        return (s[0] === 1'bx) ? 8'h00 : a;
`endif
    endfunction

    typedef struct packed {
        logic [15:0] d;
        logic        cb;
        logic        eol;
    } word_t;

    word_t exp_q[$];

    task automatic push_pair(input logic [7:0] y0, input logic [7:0] cb0, input logic [7:0] cr0,
                             input logic [7:0] y1, input logic [7:0] cb1, input logic [7:0] cr1,
                             input logic eol);
        exp_q.push_back('{d: {chroma(cb0, cb1), y0}, cb: 1'b1, eol: 1'b0});
        exp_q.push_back('{d: {chroma(cr0, cr1), y1}, cb: 1'b0, eol: eol});
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            iv[k] = 1'b0; iy[k] = '0; icb[k] = '0; icr[k] = '0; ordy[k] = 1'b0;
        end

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(ov[0]), 32'd0);
        check("rst_in_ready",  32'(ir[0]), 32'd0);
        check("rst_out_data",  32'(od[0]), 32'd0);
        check("rst_is_cb",     32'(ocb[0]), 32'd0);
        check("rst_eol",       32'(oeol[0]), 32'd0);
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(ir[0]), 32'd1);

        // ---------------- basic pair, latency ----------------
        send_pixel(0, 8'd100, 8'd120, 8'd130);
        check("p0_no_word", 32'(ov[0]), 32'd0);
        send_pixel(0, 8'd102, 8'd121, 8'd140);
        check("lat_word0", 32'(ov[0]), 32'd1);
`ifdef CHROMA_AVG_EN
        expect_word(0, "pair_w0", 16'h7964, 1'b1, 1'b0);
        expect_word(0, "pair_w1", 16'h8766, 1'b0, 1'b0);
`else
        expect_word(0, "pair_w0", 16'h7864, 1'b1, 1'b0);
        expect_word(0, "pair_w1", 16'h8266, 1'b0, 1'b0);
`endif

        // ---------------- backpressure in S_W0 ----------------
        send_pixel(0, 8'd1, 8'd2, 8'd3);
        send_pixel(0, 8'd4, 8'd5, 8'd6);
        iv[0] = 1'b1; iy[0] = 8'hEE; icb[0] = 8'hEE; icr[0] = 8'hEE;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
`ifdef CHROMA_AVG_EN
            check("stall_data", 32'(od[0]), 32'h0401);
`else
            check("stall_data", 32'(od[0]), 32'h0201);
`endif
            check("stall_valid", 32'(ov[0]), 32'd1);
            check("stall_in_ready", 32'(ir[0]), 32'd0);
        end
        iv[0] = 1'b0;
`ifdef CHROMA_AVG_EN
        expect_word(0, "stall_w0", 16'h0401, 1'b1, 1'b0);
        expect_word(0, "stall_w1", 16'h0504, 1'b0, 1'b0);
`else
        expect_word(0, "stall_w0", 16'h0201, 1'b1, 1'b0);
        expect_word(0, "stall_w1", 16'h0304, 1'b0, 1'b0);
`endif
        @(negedge clk);
        check("stall_no_dup", 32'(ov[0]), 32'd0);

        // ---------------- odd line, LINE_W=3 ----------------
        send_pixel(1, 8'd10, 8'd20, 8'd30);
        send_pixel(1, 8'd12, 8'd22, 8'd32);
`ifdef CHROMA_AVG_EN
        expect_word(1, "odd_w0", 16'h150A, 1'b1, 1'b0);
        expect_word(1, "odd_w1", 16'h1F0C, 1'b0, 1'b0);
`else
        expect_word(1, "odd_w0", 16'h140A, 1'b1, 1'b0);
        expect_word(1, "odd_w1", 16'h1E0C, 1'b0, 1'b0);
`endif
        send_pixel(1, 8'd14, 8'd24, 8'd34);
        expect_word(1, "odd_w2", 16'h180E, 1'b1, 1'b0);
        expect_word(1, "odd_w3", 16'h220E, 1'b0, 1'b1);

        // ---------------- reset mid-pair ----------------
        send_pixel(1, 8'd50, 8'd60, 8'd70);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(ov[1]), 32'd0);
        check("mid_rst_in_ready",  32'(ir[1]), 32'd0);
        check("mid_rst_out_data",  32'(od[1]), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_release_ready", 32'(ir[1]), 32'd1);
        send_pixel(1, 8'd1, 8'd2, 8'd3);
        send_pixel(1, 8'd5, 8'd6, 8'd7);
`ifdef CHROMA_AVG_EN
        expect_word(1, "fresh_w0", 16'h0401, 1'b1, 1'b0);
        expect_word(1, "fresh_w1", 16'h0505, 1'b0, 1'b0);
`else
        expect_word(1, "fresh_w0", 16'h0201, 1'b1, 1'b0);
        expect_word(1, "fresh_w1", 16'h0305, 1'b0, 1'b0);
`endif
        send_pixel(1, 8'd9, 8'd8, 8'd7);
        expect_word(1, "fresh_w2", 16'h0809, 1'b1, 1'b0);
        expect_word(1, "fresh_w3", 16'h0709, 1'b0, 1'b1);

        // ---------------- random gaps, 4 lines of LINE_W=5 ----------------
        begin
            int         pi     = 0;
            int         m_col  = 0;
            logic       have0  = 1'b0;
            logic [7:0] p0y = '0, p0cb = '0, p0cr = '0;
            int         words  = 0;
            int         eols   = 0;
            int         cyc    = 0;
            word_t      w;
            while (!(pi == NPIX && exp_q.size() == 0) && cyc < 3000) begin
                @(negedge clk);
                cyc++;
                iv[2]   = (pi < NPIX) && ($urandom_range(0, 3) != 0);
                iy[2]   = 8'(pi * 9 + 1);
                icb[2]  = 8'(pi * 37);
                icr[2]  = 8'(255 - pi * 11);
                ordy[2] = ($urandom_range(0, 3) != 0);
                #1;
                if (iv[2] && ir[2]) begin
                    if (!have0) begin
                        p0y = iy[2]; p0cb = icb[2]; p0cr = icr[2];
                        if (m_col == LW2 - 1) push_pair(p0y, p0cb, p0cr, p0y, p0cb, p0cr, 1'b1);
                        else                  have0 = 1'b1;
                    end else begin
                        push_pair(p0y, p0cb, p0cr, iy[2], icb[2], icr[2], m_col == LW2 - 1);
                        have0 = 1'b0;
                    end
                    m_col = (m_col + 1) % LW2;
                    pi++;
                end
                if (ov[2] && ordy[2]) begin
                    words++;
                    if (oeol[2]) eols++;
                    if (exp_q.size() == 0) begin
                        check("rand_extra_word", 32'(words), 32'd0);
                    end else begin
                        w = exp_q.pop_front();
                        check("rand_data",  32'(od[2]),   32'(w.d));
                        check("rand_is_cb", 32'(ocb[2]),  32'(w.cb));
                        check("rand_eol",   32'(oeol[2]), 32'(w.eol));
                    end
                end
            end
            iv[2]   = 1'b0;
            ordy[2] = 1'b0;
            check("rand_pixels_sent", 32'(pi), 32'(NPIX));
            check("rand_word_count", 32'(words), 32'(LINES * 2 * ((LW2 + 1) / 2)));
            check("rand_eol_count",  32'(eols),  32'(LINES));
            check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
